data_cache_writeback_reader: RTL and testbench

DATA_CACHE_WRITEBACK_READER -- requirements
Module: data_cache_writeback_reader

---
 rtl/data_cache_writeback_reader.sv | 155 +++++++++++++++
 tb/tb_data_cache_writeback_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_writeback_reader.sv
// Streams one cache line (BANKS beats) from the cache block read port to a valid/ready writeback port.
// Optional macro DCACHE_WB_SKID_EN: 2-entry output FIFO with read issue from registered state only.
module data_cache_writeback_reader #(
  parameter int unsigned BANKS  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        index_i,
  output logic                     idle_o,
  output logic                     done_o,
  output logic                     cache_read_o,
  output logic [$clog2(BANKS)-1:0] cache_bank_select_o,
  output logic [ADDR_W-1:0]        cache_address_o,
  input  logic [DATA_W-1:0]        cache_data_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [DATA_W-1:0]        wb_data_o,
  output logic                     wb_last_o
);

  localparam int unsigned BANK_W = $clog2(BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                done_q, done_d;

  // Read in flight: cache_data_i carries this bank's word in the current cycle.
  logic                infl_q;
  logic [BANK_W-1:0]   infl_bank_q;

  // Output buffer, entry 0 is the head.
  logic [DATA_W-1:0]   slot_data_q [2];
  logic [BANK_W-1:0]   slot_bank_q [2];
  logic [1:0]          cnt_q;

  logic                pop_c;
  logic                fifo_pop_c;
  logic                bypass_c;
  logic                push_c;
  logic                issue_c;
  logic [2:0]          occ_c;
  logic [BANK_W-1:0]   out_bank_c;
  logic                wr_idx_c;

  // Head of the buffer, or the arriving word directly when the buffer is empty.
  assign wb_valid_o = (cnt_q != 2'd0) | infl_q;
  assign wb_data_o  = (cnt_q != 2'd0) ? slot_data_q[0] :
                      (infl_q ? cache_data_i : '0);
  assign out_bank_c = (cnt_q != 2'd0) ? slot_bank_q[0] : infl_bank_q;
  assign wb_last_o  = wb_valid_o & (out_bank_c == BANK_W'(BANKS - 1));

  assign pop_c      = wb_valid_o & wb_ready_i;
  assign fifo_pop_c = (cnt_q != 2'd0) & wb_ready_i;
  assign bypass_c   = infl_q & (cnt_q == 2'd0) & wb_ready_i;
  assign push_c     = infl_q & ~bypass_c;
  assign wr_idx_c   = 1'(cnt_q - 2'(fifo_pop_c));
  assign occ_c      = 3'(cnt_q) + 3'(infl_q);

`ifdef DCACHE_WB_SKID_EN
  // Credit check on registered occupancy only; the FIFO absorbs the in-flight word.
  assign issue_c = (state_q == READ) & (occ_c < 3'd2);
`else
  // Single slot: everything held must leave this cycle before a new read goes out.
  assign issue_c = (state_q == READ) & (occ_c == 3'(pop_c));
`endif

  assign cache_read_o        = issue_c;
  assign cache_bank_select_o = bank_q;
  assign cache_address_o     = addr_q;
  assign idle_o              = (state_q == IDLE);
  assign done_o              = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          addr_d  = index_i;
          bank_d  = '0;
        end
      end
      READ: begin
        if (issue_c) begin
          bank_d = bank_q + BANK_W'(1);
          if (bank_q == BANK_W'(BANKS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_c && wb_last_o) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bank_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      done_q  <= done_d;
    end
  end

  // Read pipeline tag and output buffer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      infl_q         <= 1'b0;
      infl_bank_q    <= '0;
      cnt_q          <= 2'd0;
      slot_data_q[0] <= '0;
      slot_data_q[1] <= '0;
      slot_bank_q[0] <= '0;
      slot_bank_q[1] <= '0;
    end else begin
      infl_q <= issue_c;
      if (issue_c) begin
        infl_bank_q <= bank_q;
      end
      if (fifo_pop_c) begin
        slot_data_q[0] <= slot_data_q[1];
        slot_bank_q[0] <= slot_bank_q[1];
      end
      if (push_c) begin
        slot_data_q[wr_idx_c] <= cache_data_i;
        slot_bank_q[wr_idx_c] <= infl_bank_q;
      end
      cnt_q <= 2'(cnt_q + 2'(push_c) - 2'(fifo_pop_c));
    end
  end

endmodule

// File: tb/tb_data_cache_writeback_reader.sv
// Directed + randomized bench for data_cache_writeback_reader against a line-level reference model.
module tb_data_cache_writeback_reader;

  localparam int unsigned BANKS  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;
`ifdef DCACHE_WB_SKID_EN
  localparam int STALL_OUTSTANDING = 2;
`else
  localparam int STALL_OUTSTANDING = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] index;
  logic              idle, done, cache_read;
  logic [1:0]        bank_sel;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_data;
  logic              wb_valid, wb_ready, wb_last;
  logic [DATA_W-1:0] wb_data;

  data_cache_writeback_reader #(.BANKS(BANKS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .index_i(index),
    .idle_o(idle), .done_o(done), .cache_read_o(cache_read),
    .cache_bank_select_o(bank_sel), .cache_address_o(cache_addr),
    .cache_data_i(cache_data), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_data_o(wb_data), .wb_last_o(wb_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] salt;

  // Line contents: each (index, bank) word is a distinct scrambled value.
  function automatic logic [31:0] line_word(input logic [ADDR_W-1:0] a, input int b);
    logic [31:0] key;
    key = (32'(a) << 2) | 32'(b);
    return salt ^ (key * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read cache: word valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (cache_read) cache_data <= line_word(cache_addr, int'(bank_sel));
    else            cache_data <= $urandom;
  end

  // Observation records for the current writeback.
  int   rd_bank[$];
  int   rd_addr[$];
  int   rd_cyc[$];
  logic [31:0] bt_data[$];
  logic bt_last[$];
  int   bt_cyc[$];
  int   done_cyc[$];
  logic done_idle[$];
  int   max_out;
  int   stab_err;
  logic stall_prev;
  logic [31:0] prev_d;
  logic prev_l;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cache_read) begin
        rd_bank.push_back(int'(bank_sel));
        rd_addr.push_back(int'(cache_addr));
        rd_cyc.push_back(cyc);
      end
      if (wb_valid && wb_ready) begin
        bt_data.push_back(wb_data);
        bt_last.push_back(wb_last);
        bt_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        done_idle.push_back(idle);
      end
      if (rd_bank.size() - bt_data.size() > max_out) max_out = rd_bank.size() - bt_data.size();
      if (stall_prev && (!wb_valid || wb_data !== prev_d || wb_last !== prev_l)) stab_err++;
      stall_prev = wb_valid & ~wb_ready;
      prev_d = wb_data;
      prev_l = wb_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Backpressure generator: 0 always ready, 1 ten-cycle stall after first valid, 2 toggle, 3 random.
  int   mode = 0;
  logic seen_valid;
  int   stall_n;
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: wb_ready = 1'b1;
        1: begin
          if (wb_valid) seen_valid = 1'b1;
          if (seen_valid) stall_n++;
          wb_ready = seen_valid && (stall_n > 10);
        end
        2: wb_ready = ~wb_ready;
        default: wb_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_wb(input logic [ADDR_W-1:0] idx, input int m, output int t0);
    rd_bank.delete(); rd_addr.delete(); rd_cyc.delete();
    bt_data.delete(); bt_last.delete(); bt_cyc.delete();
    done_cyc.delete(); done_idle.delete();
    max_out = 0; stab_err = 0; seen_valid = 1'b0; stall_n = 0;
    mode = m;
    @(posedge clk); #1;
    start = 1'b1;
    index = idx;
    @(negedge clk); #1;
    t0 = cyc;
    check("idle_before_start", 64'(idle), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    index = ADDR_W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cyc.size() != 0), 64'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Line-level expectations: BANKS reads at idx in bank order, BANKS beats carrying the line, one done.
  task automatic verify_line(input string tag, input logic [ADDR_W-1:0] idx);
    check({tag, "_reads"}, 64'(rd_bank.size()), 64'(BANKS));
    check({tag, "_beats"}, 64'(bt_data.size()), 64'(BANKS));
    for (int b = 0; b < BANKS; b++) begin
      if (b < rd_bank.size()) begin
        check($sformatf("%s_rd_bank%0d", tag, b), 64'(rd_bank[b]), 64'(b));
        check($sformatf("%s_rd_addr%0d", tag, b), 64'(rd_addr[b]), 64'(idx));
      end
      if (b < bt_data.size()) begin
        check($sformatf("%s_data%0d", tag, b), 64'(bt_data[b]), 64'(line_word(idx, b)));
        check($sformatf("%s_last%0d", tag, b), 64'(bt_last[b]), 64'(b == BANKS - 1));
      end
    end
    check({tag, "_done_count"}, 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() == 1 && bt_cyc.size() == BANKS) begin
      check({tag, "_done_after_last"}, 64'(done_cyc[0]), 64'(bt_cyc[BANKS-1] + 1));
      check({tag, "_idle_with_done"}, 64'(done_idle[0]), 64'd1);
    end
    check({tag, "_stable_hold"}, 64'(stab_err), 64'd0);
    check({tag, "_idle_after"}, 64'(idle), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, 64'(idle), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_read"}, 64'(cache_read), 64'd0);
    check({tag, "_bank"}, 64'(bank_sel), 64'd0);
    check({tag, "_addr"}, 64'(cache_addr), 64'd0);
    check({tag, "_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_data"}, 64'(wb_data), 64'd0);
    check({tag, "_last"}, 64'(wb_last), 64'd0);
  endtask

  initial begin
    int t0;
    int n;
    logic [ADDR_W-1:0] idx;

    salt  = $urandom;
    rst_n = 1'b0;
    start = 1'b0;
    index = '0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-rate writeback with exact cycle timing.
    start_wb(9'h1A5, 0, t0);
    wait_done("full", 100);
    verify_line("full", 9'h1A5);
    for (int b = 0; b < BANKS; b++) begin
      if (b < rd_cyc.size()) check($sformatf("full_rd_cyc%0d", b), 64'(rd_cyc[b]), 64'(t0 + 1 + b));
      if (b < bt_cyc.size()) check($sformatf("full_bt_cyc%0d", b), 64'(bt_cyc[b]), 64'(t0 + 2 + b));
    end
    if (done_cyc.size() > 0) check("full_done_cyc", 64'(done_cyc[0]), 64'(t0 + 2 + BANKS));

    // Ten-cycle stall on the first beat, then continuous drain.
    idx = ADDR_W'($urandom);
    start_wb(idx, 1, t0);
    wait_done("stall", 200);
    verify_line("stall", idx);
    check("stall_outstanding", 64'(max_out), 64'(STALL_OUTSTANDING));
    if (bt_cyc.size() == BANKS) begin
      check("stall_beat0_cyc", 64'(bt_cyc[0]), 64'(t0 + 12));
      check("stall_beat3_cyc", 64'(bt_cyc[3]), 64'(t0 + 15));
    end

    // Alternating ready.
    idx = ADDR_W'($urandom);
    start_wb(idx, 2, t0);
    wait_done("toggle", 200);
    verify_line("toggle", idx);

    // A start pulse with another index while reading must be ignored.
    start_wb(9'h03C, 0, t0);
    start = 1'b1;
    index = 9'h0FF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 100);
    verify_line("busy_start", 9'h03C);

    // Asynchronous reset after the second beat handshake.
    idx = ADDR_W'($urandom);
    start_wb(idx, 0, t0);
    n = 0;
    while (bt_data.size() < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_beats_before", 64'(bt_data.size()), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("held_rst");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_no_done", 64'(done_cyc.size()), 64'd0);
    check("rst_no_more_beats", 64'(bt_data.size()), 64'd2);
    idx = ADDR_W'($urandom);
    start_wb(idx, 3, t0);
    wait_done("post_rst", 300);
    verify_line("post_rst", idx);

    // Random indices under random backpressure.
    for (int k = 0; k < 4; k++) begin
      idx = ADDR_W'($urandom);
      start_wb(idx, 3, t0);
      wait_done($sformatf("rand%0d", k), 300);
      verify_line($sformatf("rand%0d", k), idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
